// File: rtl/carbonez90_sim_io_pkg.sv
// Shared definitions for the CarbonEZ90 simulation I/O peripheral:
// port map, STATUS bit layout and the power-off state machine encoding.
package carbonez90_sim_io_pkg;

  localparam logic [7:0] SIMIO_SIG_DATA = 8'h00;
  localparam logic [7:0] SIMIO_SIG_CLR  = 8'h01;
  localparam logic [7:0] SIMIO_CON_TX   = 8'h02;
  localparam logic [7:0] SIMIO_STATUS   = 8'h03;
  localparam logic [7:0] SIMIO_POWEROFF = 8'h04;
  localparam logic [7:0] SIMIO_SIG_BYTE = 8'h05;

  localparam int STATUS_FULL_BIT     = 0;
  localparam int STATUS_EMPTY_BIT    = 1;
  localparam int STATUS_ARMED_BIT    = 2;
  localparam int STATUS_POWEROFF_BIT = 3;

  localparam logic [7:0] POWEROFF_MAGIC_DEFAULT = 8'hA5;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    ARMED = 2'd1,
    OFF   = 2'd2
  } sim_io_state_e;

endpackage

// File: rtl/carbonez90_sim_fifo.sv
// First-word fall-through circular FIFO. A push while full is taken only
// when a pop retires the head in the same cycle; a pop while empty is dropped.
module carbonez90_sim_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] rdata
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_COUNT = DEPTH[AW:0];

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [AW:0]      count_r;
  logic             do_push_s;
  logic             do_pop_s;

  assign full      = (count_r == FULL_COUNT);
  assign empty     = (count_r == {(AW+1){1'b0}});
  assign do_pop_s  = pop && !empty;
  assign do_push_s = push && (!full || do_pop_s);
  assign rdata     = empty ? {WIDTH{1'b0}} : mem_r[rd_ptr_r];

  // Storage array; never reset because empty masks stale entries.
  always_ff @(posedge clk) begin
    if (do_push_s) begin
      mem_r[wr_ptr_r] <= wdata;
    end
  end

  // Pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {(AW+1){1'b0}};
    end else begin
      if (do_push_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1);
      end
      if (do_pop_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + (AW+1)'(1);
        2'b01:   count_r <= count_r - (AW+1)'(1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/carbonez90_sim_io.sv
// CarbonEZ90 simulation I/O port: signature shift register, console FIFO and
// a power-off request that only completes once the console has drained.
module carbonez90_sim_io
  import carbonez90_sim_io_pkg::*;
#(
  parameter int          FIFO_DEPTH     = 8,
  parameter logic [7:0]  POWEROFF_MAGIC = POWEROFF_MAGIC_DEFAULT,
  parameter logic [31:0] SIG_RESET      = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        io_req,
  input  logic        io_we,
  input  logic [7:0]  io_addr,
  input  logic [7:0]  io_wdata,
  output logic [7:0]  io_rdata,
  output logic        io_ready,
  output logic        con_valid,
  output logic [7:0]  con_data,
  input  logic        con_ready,
  output logic [31:0] signature,
  output logic        poweroff
);

  sim_io_state_e state_r;
  sim_io_state_e state_next_s;
  logic [31:0]   signature_r;
  logic          poweroff_r;
  logic          fifo_full_s;
  logic          fifo_empty_s;
  logic          fifo_pop_s;
  logic          fifo_push_s;
  logic          stall_s;
  logic          wr_s;
  logic          live_wr_s;
  logic          arm_s;
  logic [7:0]    status_s;

  assign fifo_pop_s  = !fifo_empty_s && con_ready;
  // A full FIFO stalls CON_TX unless the sink frees a slot this very cycle.
  assign stall_s     = io_req && io_we && (io_addr == SIMIO_CON_TX) && fifo_full_s && !fifo_pop_s;
  assign io_ready    = rst_n && io_req && !stall_s;
  assign wr_s        = io_ready && io_we;
  assign live_wr_s   = wr_s && (state_r != OFF);
  assign fifo_push_s = live_wr_s && (io_addr == SIMIO_CON_TX);
  assign arm_s       = wr_s && (io_addr == SIMIO_POWEROFF) && (io_wdata == POWEROFF_MAGIC);

  assign con_valid = !fifo_empty_s;
  assign signature = signature_r;
  assign poweroff  = poweroff_r;

  carbonez90_sim_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (fifo_push_s),
    .pop   (fifo_pop_s),
    .wdata (io_wdata),
    .full  (fifo_full_s),
    .empty (fifo_empty_s),
    .rdata (con_data)
  );

  // Signature register: bytes enter at the top and shift toward the LSB.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      signature_r <= SIG_RESET;
    end else if (live_wr_s) begin
      case (io_addr)
        SIMIO_SIG_DATA: signature_r <= {io_wdata, signature_r[31:8]};
        SIMIO_SIG_CLR:  signature_r <= SIG_RESET;
        default:        signature_r <= signature_r;
      endcase
    end else begin
      signature_r <= signature_r;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= RUN;
    end else begin
      state_r <= state_next_s;
    end
  end

  // FSM next state; a push landing in the same cycle keeps ARMED draining.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      RUN: begin
        if (arm_s) state_next_s = ARMED;
        else       state_next_s = RUN;
      end
      ARMED: begin
        if (fifo_empty_s && !fifo_push_s) state_next_s = OFF;
        else                              state_next_s = ARMED;
      end
      OFF:     state_next_s = OFF;
      default: state_next_s = RUN;
    endcase
  end

  // FSM output register: poweroff tracks state == OFF exactly.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      poweroff_r <= 1'b0;
    end else begin
      poweroff_r <= (state_next_s == OFF);
    end
  end

  // STATUS word assembly.
  always_comb begin
    status_s                      = 8'h00;
    status_s[STATUS_FULL_BIT]     = fifo_full_s;
    status_s[STATUS_EMPTY_BIT]    = fifo_empty_s;
    status_s[STATUS_ARMED_BIT]    = (state_r == ARMED);
    status_s[STATUS_POWEROFF_BIT] = poweroff_r;
  end

  // Read data mux, driven only during an accepted read.
  always_comb begin
    io_rdata = 8'h00;
    if (io_ready && !io_we) begin
      case (io_addr)
        SIMIO_STATUS:   io_rdata = status_s;
        SIMIO_SIG_BYTE: io_rdata = signature_r[7:0];
        default:        io_rdata = 8'h00;
      endcase
    end else begin
      io_rdata = 8'h00;
    end
  end

endmodule
